// File: rtl/mix_mc.sv
// Multi-channel envelope mixer: DC_POST[k] = clamp(DC_PRE[k] +/- ENV[k]*MUL[k]).
// One shared multiplier is stepped across the channels, one per cycle, behind a start/done handshake.
module mix_mc #(
    parameter int PWM_DEPTH = 12,
    parameter int ENV_W     = 7,
    parameter int MUL_W     = 5,
    parameter int CHANNELS  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          START,
    input  logic [CHANNELS*ENV_W-1:0]     ENV,
    input  logic [CHANNELS*PWM_DEPTH-1:0] DC_PRE,
    input  logic [CHANNELS*MUL_W-1:0]     MUL,
    input  logic [CHANNELS-1:0]           MODE,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [CHANNELS*PWM_DEPTH-1:0] DC_POST
);

    localparam int PROD_W = ENV_W + MUL_W;
    localparam int W      = ((PWM_DEPTH > PROD_W) ? PWM_DEPTH : PROD_W) + 2;
    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [PWM_DEPTH-1:0] DC_MAX   = '1;
    localparam logic signed [W-1:0]  S_DC_MAX = signed'(W'(DC_MAX));
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(CHANNELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

    state_t                          r_state;
    logic [IDX_W-1:0]                r_idx;

    logic [CHANNELS*ENV_W-1:0]       r_env;
    logic [CHANNELS*PWM_DEPTH-1:0]   r_dc;
    logic [CHANNELS*MUL_W-1:0]       r_mul;
    logic [CHANNELS-1:0]             r_mode;

    logic [PROD_W-1:0]               r_prod_p1;
    logic [PWM_DEPTH-1:0]            r_dc_p1;
    logic                            r_mode_p1;
    logic [IDX_W-1:0]                r_ch_p1;
    logic                            r_vld_p1;

    logic [ENV_W-1:0]                w_env;
    logic [MUL_W-1:0]                w_mul;
    logic [PWM_DEPTH-1:0]            w_dc;
    logic                            w_mode;

    // Widened signed arithmetic so neither direction can wrap before the clamp.
    function automatic logic [PWM_DEPTH-1:0] sat_mix(
        input logic [PWM_DEPTH-1:0] dc,
        input logic [PROD_W-1:0]    prod,
        input logic                 sub
    );
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        logic signed [W-1:0] s;
        a = signed'(W'(dc));
        b = signed'(W'(prod));
        s = sub ? (a - b) : (a + b);
        if (s < 0)
            return '0;
        else if (s > S_DC_MAX)
            return DC_MAX;
        else
            return s[PWM_DEPTH-1:0];
    endfunction

    assign w_env  = r_env[r_idx*ENV_W +: ENV_W];
    assign w_mul  = r_mul[r_idx*MUL_W +: MUL_W];
    assign w_dc   = r_dc[r_idx*PWM_DEPTH +: PWM_DEPTH];
    assign w_mode = r_mode[r_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else begin
            DONE     <= 1'b0;
            r_vld_p1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        BUSY    <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_vld_p1 <= 1'b1;
                    if (r_idx == LAST_IDX)
                        r_state <= S_FLUSH;
                    else
                        r_idx <= r_idx + 1'b1;
                end
                S_FLUSH: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    BUSY    <= 1'b0;
                    DONE    <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stage 0: input snapshot. Stage 1: shared multiply for the issued channel.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && START) begin
            r_env  <= ENV;
            r_dc   <= DC_PRE;
            r_mul  <= MUL;
            r_mode <= MODE;
        end
        if (r_state == S_RUN) begin
            r_prod_p1 <= w_env * w_mul;
            r_dc_p1   <= w_dc;
            r_mode_p1 <= w_mode;
            r_ch_p1   <= r_idx;
        end
    end

    // Stage 2: clamp and write back the channel that left stage 1.
    always_ff @(posedge clk) begin
        if (rst)
            DC_POST <= '0;
        else if (r_vld_p1)
            DC_POST[r_ch_p1*PWM_DEPTH +: PWM_DEPTH] <= sat_mix(r_dc_p1, r_prod_p1, r_mode_p1);
    end

endmodule

// File: tb/tb_mix_mc.sv
// Directed bench for mix_mc: hand-computed duty cycles, latency, ordering, snapshot and reset.
module tb_mix_mc;

    localparam int PWM_DEPTH = 12;
    localparam int ENV_W     = 7;
    localparam int MUL_W     = 5;
    localparam int CHANNELS  = 4;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          START;
    logic [CHANNELS*ENV_W-1:0]     ENV;
    logic [CHANNELS*PWM_DEPTH-1:0] DC_PRE;
    logic [CHANNELS*MUL_W-1:0]     MUL;
    logic [CHANNELS-1:0]           MODE;
    logic                          BUSY;
    logic                          DONE;
    logic [CHANNELS*PWM_DEPTH-1:0] DC_POST;

    int passes = 0;
    int total  = 0;

    mix_mc #(
        .PWM_DEPTH(PWM_DEPTH),
        .ENV_W    (ENV_W),
        .MUL_W    (MUL_W),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .START  (START),
        .ENV    (ENV),
        .DC_PRE (DC_PRE),
        .MUL    (MUL),
        .MODE   (MODE),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .DC_POST(DC_POST)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic logic [31:0] dcp(input int k);
        return 32'(DC_POST[k*PWM_DEPTH +: PWM_DEPTH]);
    endfunction

    task automatic set_ch(input int k, input int e, input int dc, input int m, input logic md);
        ENV[k*ENV_W +: ENV_W]          = ENV_W'(e);
        DC_PRE[k*PWM_DEPTH +: PWM_DEPTH] = PWM_DEPTH'(dc);
        MUL[k*MUL_W +: MUL_W]          = MUL_W'(m);
        MODE[k]                        = md;
    endtask

    task automatic check_all(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk($sformatf("%s_ch0", tag), dcp(0), 32'(e0));
        chk($sformatf("%s_ch1", tag), dcp(1), 32'(e1));
        chk($sformatf("%s_ch2", tag), dcp(2), 32'(e2));
        chk($sformatf("%s_ch3", tag), dcp(3), 32'(e3));
    endtask

    // Pulses START and returns just after the edge where DONE is first seen high.
    task automatic run(output int lat, output int bcnt);
        START = 1'b1;
        step();
        START = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (DONE !== 1'b1 && lat < 20) begin
            if (BUSY === 1'b1) bcnt++;
            step();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int hits;

        rst = 1'b1; START = 1'b0; ENV = '0; DC_PRE = '0; MUL = '0; MODE = '0;
        step();
        step();
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        check_all("rst_dc", 0, 0, 0, 0);
        rst = 1'b0;
        step();

        // Basic add: 5 + 2*4 = 13 everywhere
        for (int k = 0; k < CHANNELS; k++) set_ch(k, 2, 5, 4, 1'b0);
        run(lat, bcnt);
        chk("add_latency", 32'(lat), 32'd5);
        chk("add_busy_cycles", 32'(bcnt), 32'd5);
        chk("add_busy_at_done", 32'(BUSY), 32'd0);
        check_all("add", 13, 13, 13, 13);
        step();
        chk("add_done_pulse", 32'(DONE), 32'd0);

        // Saturation high; ch3 lands exactly on full scale (158 + 3937)
        set_ch(0, 125, 255, 31, 1'b0);
        set_ch(1, 125, 255, 31, 1'b0);
        set_ch(2, 127, 4095, 31, 1'b0);
        set_ch(3, 127, 158, 31, 1'b0);
        run(lat, bcnt);
        chk("sat_latency", 32'(lat), 32'd5);
        check_all("sat", 4095, 4095, 4095, 4095);
        step();

        // Subtract and floor
        set_ch(0, 2, 1000, 4, 1'b1);
        set_ch(1, 2, 5, 4, 1'b1);
        set_ch(2, 50, 777, 0, 1'b1);
        set_ch(3, 2, 5, 4, 1'b0);
        run(lat, bcnt);
        check_all("sub", 992, 0, 777, 13);
        step();

        // Ordering, snapshot and ignored START
        for (int k = 0; k < CHANNELS; k++) set_ch(k, k + 1, 100 * (k + 1), k + 2, 1'b0);
        START = 1'b1;
        step();
        START = 1'b0;
        chk("ord_busy_e0", 32'(BUSY), 32'd1);
        step();
        check_all("ord_e1", 992, 0, 777, 13);
        for (int k = 0; k < CHANNELS; k++) set_ch(k, 127, 4000, 31, 1'b1);
        START = 1'b1;
        step();
        check_all("ord_e2", 102, 0, 777, 13);
        step();
        check_all("ord_e3", 102, 206, 777, 13);
        step();
        check_all("ord_e4", 102, 206, 312, 13);
        chk("ord_done_e4", 32'(DONE), 32'd0);
        step();
        check_all("ord_e5", 102, 206, 312, 420);
        chk("ord_done_e5", 32'(DONE), 32'd1);
        START = 1'b0;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (DONE === 1'b1 || BUSY === 1'b1) hits++;
        end
        chk("ord_no_second_pass", 32'(hits), 32'd0);
        check_all("ord_hold", 102, 206, 312, 420);

        // Reset in the middle of a pass
        set_ch(0, 3, 50, 10, 1'b0);
        set_ch(1, 3, 50, 10, 1'b1);
        set_ch(2, 3, 50, 10, 1'b0);
        set_ch(3, 3, 50, 10, 1'b1);
        START = 1'b1;
        step();
        START = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("mrst_busy", 32'(BUSY), 32'd0);
        chk("mrst_done", 32'(DONE), 32'd0);
        check_all("mrst_dc", 0, 0, 0, 0);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (DONE === 1'b1 || BUSY === 1'b1) hits++;
        end
        chk("mrst_quiet", 32'(hits), 32'd0);
        check_all("mrst_hold", 0, 0, 0, 0);
        run(lat, bcnt);
        chk("mrst_latency", 32'(lat), 32'd5);
        check_all("mrst_rerun", 80, 20, 80, 20);

        // Back-to-back: START in the cycle DONE is high
        for (int k = 0; k < CHANNELS; k++) set_ch(k, 10, 1000 + k, 10, 1'(k));
        run(lat, bcnt);
        chk("b2b_latency", 32'(lat), 32'd5);
        chk("b2b_busy_cycles", 32'(bcnt), 32'd5);
        check_all("b2b", 1100, 901, 1102, 903);
        step();
        chk("b2b_done_pulse", 32'(DONE), 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
